// File: rtl/canvas_pkg.sv
// Shared grid geometry, FSM encoding and cell indexing for the handwriting canvas.
package canvas_pkg;
  localparam int GRID  = 30;
  localparam int BMP_W = GRID * GRID;
  localparam int CNT_W = 10;
  localparam int ROW_W = $clog2(GRID);

  typedef enum logic [1:0] {DRAW, CLEAR, START, FROZEN} state_t;

  function automatic int cell_idx(input int x, input int y);
    return y * GRID + x;
  endfunction
endpackage

// File: rtl/canvas_stamp.sv
// Combinational brush stamp: a clipped BMP_W-bit mask around cell (cx, cy).
module canvas_stamp
  import canvas_pkg::*;
#(
  parameter int COORD_W    = 8,
  parameter bit BRUSH_PLUS = 1'b1
) (
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  output logic [BMP_W-1:0]   mask,
  output logic               on_grid
);
  assign on_grid = (int'(cx) < GRID) && (int'(cy) < GRID);

  // Only cells that exist in the grid get a mask bit, so clipping is implicit;
  // an off-grid centre is suppressed so its in-grid neighbours stay clean.
  for (genvar gy = 0; gy < GRID; gy++) begin : g_row
    for (genvar gx = 0; gx < GRID; gx++) begin : g_col
      logic ctr, arm_x, arm_y;
      assign ctr   = (int'(cx) == gx) && (int'(cy) == gy);
      assign arm_x = (int'(cy) == gy) && ((int'(cx) == gx + 1) || (int'(cx) + 1 == gx));
      assign arm_y = (int'(cx) == gx) && ((int'(cy) == gy + 1) || (int'(cy) + 1 == gy));
      assign mask[cell_idx(gx, gy)] = on_grid && (ctr || (BRUSH_PLUS && (arm_x || arm_y)));
    end
  end
endmodule

// File: rtl/handwrite_canvas.sv
// Pen-stream to 30x30 bitmap front end: brush stamping, set-cell count, row-sweep
// clear, and a freeze handshake with the downstream classifier.
module handwrite_canvas
  import canvas_pkg::*;
#(
  parameter int COORD_W     = 8,
  parameter int SCALE_SHIFT = 3,
  parameter bit BRUSH_PLUS  = 1'b1,
  parameter bit AUTO_CLEAR  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pen_valid,
  output logic               o_pen_ready,
  input  logic [COORD_W-1:0] i_pen_x,
  input  logic [COORD_W-1:0] i_pen_y,
  input  logic               i_pen_down,
  input  logic               i_clear,
  input  logic               i_classify,
  output logic               o_start_n,
  input  logic               i_result_valid,
  output logic               o_frozen,
  output logic               o_busy,
  output logic [BMP_W-1:0]   o_handwrite,
  output logic [CNT_W-1:0]   o_set_count
);
  state_t             state, state_nx;
  logic               start_n_nx, frozen_nx, busy_nx;
  logic [ROW_W-1:0]   row;
  logic               last_row;
  logic               clr_pend;
  logic               pend_vld;
  logic [COORD_W-1:0] pend_cx, pend_cy;
  logic [BMP_W-1:0]   mask;
  logic               on_grid;
  logic               accept;
  logic [CNT_W-1:0]   add;

  assign o_pen_ready = (state == DRAW);
  assign accept      = i_pen_valid && o_pen_ready;
  assign last_row    = (row == ROW_W'(GRID - 1));
  assign add         = CNT_W'($countones(mask & ~o_handwrite));

  canvas_stamp #(.COORD_W(COORD_W), .BRUSH_PLUS(BRUSH_PLUS)) u_stamp (
    .cx      (pend_cx),
    .cy      (pend_cy),
    .mask    (mask),
    .on_grid (on_grid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= DRAW;
      o_start_n <= 1'b1;
      o_frozen  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nx;
      o_start_n <= start_n_nx;
      o_frozen  <= frozen_nx;
      o_busy    <= busy_nx;
    end
  end

  // A clear requested while frozen (or arriving with the result) wins on exit.
  always_comb begin
    state_nx = state;
    case (state)
      DRAW:    if (i_clear) state_nx = CLEAR;
               else if (i_classify) state_nx = START;
      CLEAR:   if (last_row) state_nx = DRAW;
      START:   state_nx = FROZEN;
      FROZEN:  if (i_result_valid)
                 state_nx = (AUTO_CLEAR || clr_pend || i_clear) ? CLEAR : DRAW;
      default: state_nx = DRAW;
    endcase
  end

  always_comb begin
    start_n_nx = (state_nx != START);
    frozen_nx  = (state_nx == START) || (state_nx == FROZEN);
    busy_nx    = (state_nx == CLEAR);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_vld    <= 1'b0;
      pend_cx     <= '0;
      pend_cy     <= '0;
      clr_pend    <= 1'b0;
      row         <= '0;
      o_handwrite <= '0;
      o_set_count <= '0;
    end else begin
      pend_vld <= accept && i_pen_down;
      if (accept) begin
        pend_cx <= i_pen_x >> SCALE_SHIFT;
        pend_cy <= i_pen_y >> SCALE_SHIFT;
      end

      if ((state == START || state == FROZEN) && i_clear) clr_pend <= 1'b1;
      else if (state == CLEAR)                            clr_pend <= 1'b0;

      // The pending stamp lands one edge after acceptance, even in START.
      if (pend_vld && on_grid) begin
        o_handwrite <= o_handwrite | mask;
        o_set_count <= o_set_count + add;
      end

      if (state == CLEAR) begin
        row <= last_row ? '0 : row + 1'b1;
        for (int r = 0; r < GRID; r++)
          if (int'(row) == r) o_handwrite[r*GRID +: GRID] <= '0;
        if (last_row) o_set_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_handwrite_canvas.sv
// Directed bench for handwrite_canvas with hand-computed bitmaps and counts.
module tb_handwrite_canvas;
  import canvas_pkg::*;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_pen_valid = 1'b0;
  logic             o_pen_ready;
  logic [7:0]       i_pen_x = '0;
  logic [7:0]       i_pen_y = '0;
  logic             i_pen_down = 1'b0;
  logic             i_clear = 1'b0;
  logic             i_classify = 1'b0;
  logic             o_start_n;
  logic             i_result_valid = 1'b0;
  logic             o_frozen;
  logic             o_busy;
  logic [BMP_W-1:0] o_handwrite;
  logic [CNT_W-1:0] o_set_count;

  int n_chk = 0;
  int n_err = 0;

  handwrite_canvas dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pen_valid    (i_pen_valid),
    .o_pen_ready    (o_pen_ready),
    .i_pen_x        (i_pen_x),
    .i_pen_y        (i_pen_y),
    .i_pen_down     (i_pen_down),
    .i_clear        (i_clear),
    .i_classify     (i_classify),
    .o_start_n      (o_start_n),
    .i_result_valid (i_result_valid),
    .o_frozen       (o_frozen),
    .o_busy         (o_busy),
    .o_handwrite    (o_handwrite),
    .o_set_count    (o_set_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [BMP_W-1:0] got, input logic [BMP_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one sample for one cycle, then wait for its write edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic down);
    i_pen_valid = 1'b1;
    i_pen_x     = x;
    i_pen_y     = y;
    i_pen_down  = down;
    step();
    i_pen_valid = 1'b0;
    step();
  endtask

  // Called just after the edge that entered CLEAR; counts busy cycles and start pulses.
  task automatic sweep(input int poke, output int n, output int lows);
    n    = 0;
    lows = 0;
    while (o_busy && n < 100) begin
      if (!o_start_n) lows++;
      i_clear = (n == poke);
      n++;
      step();
    end
    i_clear = 1'b0;
  endtask

  logic [BMP_W-1:0] exp_bmp;
  int               n, lows;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_hw", o_handwrite, '0);
    chk("rst_cnt", o_set_count, 0);
    chk("rst_start_n", o_start_n, 1);
    chk("rst_frozen", o_frozen, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_pen_ready, 1);
    i_rst = 1'b0;
    step();

    send(8'd8, 8'd8, 1'b1);
    exp_bmp = '0;
    exp_bmp[1] = 1'b1; exp_bmp[30] = 1'b1; exp_bmp[31] = 1'b1;
    exp_bmp[32] = 1'b1; exp_bmp[61] = 1'b1;
    chk("plus_hw", o_handwrite, exp_bmp);
    chk("plus_cnt", o_set_count, 5);

    // Full clear, with a second clear mid-sweep that must be ignored.
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clr_ready", o_pen_ready, 0);
    sweep(10, n, lows);
    chk("clr_len", n, 30);
    chk("clr_hw", o_handwrite, '0);
    chk("clr_cnt", o_set_count, 0);
    chk("clr_ready_after", o_pen_ready, 1);

    // Async reset at sweep row 12 with a stamp still present in row 25.
    send(8'd200, 8'd200, 1'b1);
    chk("far_cnt", o_set_count, 5);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    repeat (12) step();
    chk("mid_busy", o_busy, 1);
    #1 i_rst = 1'b1;
    #1;
    chk("mrst_hw", o_handwrite, '0);
    chk("mrst_cnt", o_set_count, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_ready", o_pen_ready, 1);
    chk("mrst_frozen", o_frozen, 0);
    chk("mrst_start_n", o_start_n, 1);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    step();
    send(8'd8, 8'd8, 1'b1);
    chk("post_rst_hw", o_handwrite, exp_bmp);
    chk("post_rst_cnt", o_set_count, 5);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    sweep(-1, n, lows);

    // Corner clip and idempotent redraw.
    send(8'd0, 8'd0, 1'b1);
    exp_bmp = '0;
    exp_bmp[0] = 1'b1; exp_bmp[1] = 1'b1; exp_bmp[30] = 1'b1;
    chk("clip_hw", o_handwrite, exp_bmp);
    chk("clip_cnt", o_set_count, 3);
    send(8'd0, 8'd0, 1'b1);
    chk("rep_cnt", o_set_count, 3);

    chk("off_ready", o_pen_ready, 1);
    send(8'd240, 8'd0, 1'b1);
    chk("off_hw", o_handwrite, exp_bmp);
    chk("off_cnt", o_set_count, 3);

    send(8'd16, 8'd16, 1'b0);
    chk("hover_hw", o_handwrite, exp_bmp);
    chk("hover_cnt", o_set_count, 3);

    // Draw, then classify with a sample accepted in the same cycle.
    send(8'd16, 8'd16, 1'b1);
    exp_bmp[32] = 1'b1; exp_bmp[61] = 1'b1; exp_bmp[62] = 1'b1;
    exp_bmp[63] = 1'b1; exp_bmp[92] = 1'b1;
    chk("draw2_cnt", o_set_count, 8);
    i_pen_valid = 1'b1; i_pen_x = 8'd24; i_pen_y = 8'd24; i_pen_down = 1'b1;
    i_classify  = 1'b1;
    step();
    i_pen_valid = 1'b0;
    i_classify  = 1'b0;
    chk("cls_start_n", o_start_n, 0);
    chk("cls_frozen", o_frozen, 1);
    chk("cls_ready", o_pen_ready, 0);
    step();
    exp_bmp[93] = 1'b1; exp_bmp[94] = 1'b1; exp_bmp[123] = 1'b1;
    chk("cls_pulse_end", o_start_n, 1);
    chk("cls_hw", o_handwrite, exp_bmp);
    chk("cls_cnt", o_set_count, 11);
    i_pen_valid = 1'b1; i_pen_x = 8'd100; i_pen_y = 8'd100;
    lows = 0;
    repeat (4) begin
      step();
      if (!o_start_n) lows++;
    end
    chk("frz_lows", lows, 0);
    chk("frz_ready", o_pen_ready, 0);
    chk("frz_frozen", o_frozen, 1);
    chk("frz_hw", o_handwrite, exp_bmp);
    i_pen_valid    = 1'b0;
    i_result_valid = 1'b1;
    step();
    i_result_valid = 1'b0;
    chk("rel_frozen", o_frozen, 0);
    chk("rel_ready", o_pen_ready, 1);
    chk("rel_busy", o_busy, 0);
    step();
    chk("rel_hw", o_handwrite, exp_bmp);
    chk("rel_cnt", o_set_count, 11);

    // Clear and classify together: clear wins, no start pulse.
    i_clear = 1'b1; i_classify = 1'b1;
    step();
    i_clear = 1'b0; i_classify = 1'b0;
    chk("both_busy", o_busy, 1);
    sweep(-1, n, lows);
    chk("both_len", n, 30);
    chk("both_lows", lows, 0);
    chk("both_hw", o_handwrite, '0);

    // Clear latched while frozen, served on result.
    send(8'd0, 8'd0, 1'b1);
    exp_bmp = '0;
    exp_bmp[0] = 1'b1; exp_bmp[1] = 1'b1; exp_bmp[30] = 1'b1;
    i_classify = 1'b1;
    step();
    i_classify = 1'b0;
    step();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("lat_busy", o_busy, 0);
    chk("lat_frozen", o_frozen, 1);
    chk("lat_hw", o_handwrite, exp_bmp);
    repeat (2) step();
    i_result_valid = 1'b1;
    step();
    i_result_valid = 1'b0;
    chk("lat_exit_busy", o_busy, 1);
    chk("lat_exit_frozen", o_frozen, 0);
    sweep(-1, n, lows);
    chk("lat_len", n, 30);
    chk("lat_hw_clr", o_handwrite, '0);
    chk("lat_cnt_clr", o_set_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
